// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter sharing one serial "010"/"101" window detector between two requesters.
// Optional abort input enabled by defining PATTERN_SCAN_ABORT_EN.
module pattern_scan_arbiter #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clock,
   input  logic              reset_n,
`ifdef PATTERN_SCAN_ABORT_EN
   input  logic              abort,
`endif
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              res_valid,
   output logic              res_id,
   output logic [CNT_W-1:0]  res_cnt_a,
   output logic [CNT_W-1:0]  res_cnt_b,
   input  logic              res_ready,
   output logic              busy
);

   localparam int unsigned BIT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, state_d;
   logic [WORD_W-1:0] sreg, sreg_d;
   logic [1:0]        hist, hist_d;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
   logic              last_grant, last_grant_d;
   logic              res_valid_d, res_id_d, busy_d;
   logic [CNT_W-1:0]  cnt_a_d, cnt_b_d;
   logic              grant;
   logic              accept;
   logic              abort_hit;
   logic [2:0]        window;

`ifdef PATTERN_SCAN_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // On a tie the requester that did not win last time is chosen
   always_comb begin
      grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
      req0_ready = reset_n && (state == IDLE) && req0_valid && !grant;
      req1_ready = reset_n && (state == IDLE) && req1_valid && grant;
      accept     = req0_ready || req1_ready;
   end

   assign window = {hist, sreg[WORD_W-1]};

   // Next-state and datapath updates
   always_comb begin
      state_d      = state;
      sreg_d       = sreg;
      hist_d       = hist;
      bit_cnt_d    = bit_cnt;
      last_grant_d = last_grant;
      res_valid_d  = res_valid;
      res_id_d     = res_id;
      cnt_a_d      = res_cnt_a;
      cnt_b_d      = res_cnt_b;

      case (state)
         IDLE: begin
            if (accept) begin
               sreg_d       = grant ? req1_data : req0_data;
               hist_d       = 2'b00;
               bit_cnt_d    = '0;
               cnt_a_d      = '0;
               cnt_b_d      = '0;
               res_id_d     = grant;
               last_grant_d = grant;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            sreg_d    = {sreg[WORD_W-2:0], 1'b0};
            hist_d    = window[1:0];
            bit_cnt_d = bit_cnt + BIT_W'(1);
            // Windows are only complete from the third bit of the word onward
            if (bit_cnt >= BIT_W'(2)) begin
               if ((window == 3'b010) && (res_cnt_a != CNT_MAX)) cnt_a_d = res_cnt_a + CNT_W'(1);
               if ((window == 3'b101) && (res_cnt_b != CNT_MAX)) cnt_b_d = res_cnt_b + CNT_W'(1);
            end
            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
               state_d     = DONE;
               res_valid_d = 1'b1;
            end
            if (abort_hit) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         DONE: begin
            if (res_ready || abort_hit) begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         sreg       <= '0;
         hist       <= 2'b00;
         bit_cnt    <= '0;
         last_grant <= 1'b1;
         res_valid  <= 1'b0;
         res_id     <= 1'b0;
         res_cnt_a  <= '0;
         res_cnt_b  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         sreg       <= sreg_d;
         hist       <= hist_d;
         bit_cnt    <= bit_cnt_d;
         last_grant <= last_grant_d;
         res_valid  <= res_valid_d;
         res_id     <= res_id_d;
         res_cnt_a  <= cnt_a_d;
         res_cnt_b  <= cnt_b_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Directed self-checking bench for pattern_scan_arbiter (WORD_W=8, CNT_W=4).
// Abort scenario runs only when PATTERN_SCAN_ABORT_EN is defined.
module tb_pattern_scan_arbiter;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       res_valid, res_id, res_ready, busy;
   logic [3:0] res_cnt_a, res_cnt_b;
`ifdef PATTERN_SCAN_ABORT_EN
   logic       abort;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pattern_scan_arbiter #(.WORD_W(8), .CNT_W(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
`ifdef PATTERN_SCAN_ABORT_EN
      .abort      (abort),
`endif
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_cnt_a  (res_cnt_a),
      .res_cnt_b  (res_cnt_b),
      .res_ready  (res_ready),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One requester alone, result consumed immediately
   task automatic run_word(input logic id, input logic [7:0] data, input logic [3:0] ea, input logic [3:0] eb);
      if (!id) begin req0_valid = 1'b1; req0_data = data; end
      else     begin req1_valid = 1'b1; req1_data = data; end
      #1;
      check("single_ready", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check("single_busy", busy, 1);
      check("single_ready_off", {req1_ready, req0_ready}, 0);
      repeat (7) tick();
      check("single_valid_early", res_valid, 0);
      tick();
      check("single_valid", res_valid, 1);
      check("single_id", res_id, id);
      check("single_cnt_a", res_cnt_a, ea);
      check("single_cnt_b", res_cnt_b, eb);
      tick();
      check("single_valid_drop", res_valid, 0);
      check("single_busy_drop", busy, 0);
   endtask

   // Both requesters held valid; one grant and result
   task automatic both_round(input logic id, input logic [3:0] ea, input logic [3:0] eb);
      #1;
      check("rr_ready", {req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
      tick();
      check("rr_busy", busy, 1);
      check("rr_ready_off", {req1_ready, req0_ready}, 0);
      repeat (7) tick();
      check("rr_valid_early", res_valid, 0);
      tick();
      check("rr_valid", res_valid, 1);
      check("rr_id", res_id, id);
      check("rr_cnt_a", res_cnt_a, ea);
      check("rr_cnt_b", res_cnt_b, eb);
      tick();
      check("rr_valid_drop", res_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_data  = 8'h00;
      req1_data  = 8'h00;
      res_ready  = 1'b1;
`ifdef PATTERN_SCAN_ABORT_EN
      abort      = 1'b0;
`endif
      #3;
      check("rst_ready0", req0_ready, 0);
      check("rst_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_id", res_id, 0);
      check("rst_counts", {res_cnt_a, res_cnt_b}, 0);
      tick();
      tick();
      req0_valid = 1'b0;
      reset_n    = 1'b1;

      // Single requester words
      run_word(1'b0, 8'h6A, 4'd2, 4'd2);
      run_word(1'b1, 8'hAA, 4'd3, 4'd3);
      run_word(1'b1, 8'hFF, 4'd0, 4'd0);

      // Round-robin from a fresh reset
      reset_n = 1'b0;
      tick();
      reset_n    = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h55;
      req1_valid = 1'b1; req1_data = 8'h00;
      both_round(1'b0, 4'd3, 4'd3);
      both_round(1'b1, 4'd0, 4'd0);
      both_round(1'b0, 4'd3, 4'd3);
      both_round(1'b1, 4'd0, 4'd0);

      // Result held while consumer stalls
      req0_data = 8'h6A;
      req1_data = 8'hAA;
      res_ready = 1'b0;
      #1;
      check("hold_grant", {req1_ready, req0_ready}, 1);
      tick();
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", res_valid, 1);
         check("hold_id", res_id, 0);
         check("hold_cnt_a", res_cnt_a, 2);
         check("hold_cnt_b", res_cnt_b, 2);
         check("hold_busy", busy, 1);
         check("hold_ready", {req1_ready, req0_ready}, 0);
      end
      res_ready = 1'b1;
      tick();
      check("hold_release_valid", res_valid, 0);
      check("hold_release_busy", busy, 0);
      check("hold_next_grant", {req1_ready, req0_ready}, 2);
      tick();
      check("hold_accept_busy", busy, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (7) tick();
      tick();
      check("hold_r1_valid", res_valid, 1);
      check("hold_r1_id", res_id, 1);
      check("hold_r1_cnts", {res_cnt_a, res_cnt_b}, 8'h33);
      tick();

      // Reset in the middle of a shift
      req0_valid = 1'b1; req0_data = 8'h55;
      #1;
      check("mid_grant", req0_ready, 1);
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_ready", {req1_ready, req0_ready}, 0);
      check("mid_rst_out", {res_id, res_cnt_a, res_cnt_b}, 0);
      repeat (3) tick();
      check("mid_rst_no_result", res_valid, 0);
      req1_valid = 1'b1; req1_data = 8'h00;
      reset_n = 1'b1;
      both_round(1'b0, 4'd3, 4'd3);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

`ifdef PATTERN_SCAN_ABORT_EN
      // Abort req0 mid-shift; req1 must win next
      req0_valid = 1'b1; req0_data = 8'h6A;
      #1;
      check("abort_grant0", {req1_ready, req0_ready}, 1);
      tick();
      req1_valid = 1'b1; req1_data = 8'hAA;
      tick();
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_next_grant", {req1_ready, req0_ready}, 2);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (7) tick();
      check("abort_r1_early", res_valid, 0);
      tick();
      check("abort_r1_valid", res_valid, 1);
      check("abort_r1_id", res_id, 1);
      check("abort_r1_cnts", {res_cnt_a, res_cnt_b}, 8'h33);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
- Shares one serial 3-bit-window pattern detector between two requesters.
- Each requester hands over a parallel word. The arbiter grants requesters round-robin and shifts the word MSB-first through the detector.
- The detector counts overlapping occurrences of "010" (cnt_a) and "101" (cnt_b) within that word.
- The arbiter returns both counts with the requester id over a valid/ready result channel.

Parameters:
- WORD_W, 8, bits per word; must be >= 3.
- CNT_W, 4, width of each match counter; counters saturate at 2^CNT_W-1.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WORD_W  requester 0 word, MSB shifted first
- req0_ready  out  1  requester 0 word accepted this cycle when valid&&ready
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WORD_W  requester 1 word
- req1_ready  out  1  requester 1 accept strobe
- res_valid  out  1  result available
- res_id  out  1  requester whose word produced the result
- res_cnt_a  out  CNT_W  count of "010" windows
- res_cnt_b  out  CNT_W  count of "101" windows
- res_ready  in  1  consumer takes result when res_valid&&res_ready
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Clock port is named clock. Reset port is named reset_n; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - res_valid=0, res_id=0, res_cnt_a=0, res_cnt_b=0, busy=0.
  - reqN_ready=0 combinationally during reset.
  - last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - reqN_ready is combinational. It is 1 only for the selected requester, and only when that requester's valid=1.
  - Selection rule: if both are valid, the requester != last_grant wins. Otherwise the single valid requester wins.
  - On the accept edge:
    - the word loads into the shift register;
    - window history and bit counter clear to 0;
    - cnt_a and cnt_b clear to 0;
    - res_id is set to the grantee and last_grant is updated;
    - state goes to SHIFT.
- SHIFT:
  - One bit per edge, MSB first. The window holds the last 3 bits shifted.
  - From the 3rd bit onward, on each edge: window=="010" increments cnt_a; window=="101" increments cnt_b.
  - Both counters saturate at 2^CNT_W-1.
  - Windows never span two words.
  - After exactly WORD_W shift edges, go to DONE. res_valid goes to 1 on the WORD_W-th shift edge after acceptance.
- DONE:
  - res_valid=1. res_id, res_cnt_a and res_cnt_b are held stable until res_valid&&res_ready.
  - On that edge: res_valid=0, state goes to IDLE.
  - A new word cannot be accepted on the same edge. This gives a minimum one-cycle bubble, so the throughput limit is one word per WORD_W+2 cycles.
- reqN_ready is 0 in SHIFT and DONE. Requests are held, never dropped.
- Reset mid-operation:
  - All state clears immediately and asynchronously. The in-flight word and any pending result are discarded with no res_valid pulse.
  - After release, a tie grants req0.
- res_ready while res_valid=0 is ignored. reqN_data is sampled only on the accept edge.

Optional Feature:
- Macro: PATTERN_SCAN_ABORT_EN.
- When defined:
  - Extra input port abort, 1 bit.
  - abort=1 in SHIFT or DONE returns to IDLE on the next edge, clears res_valid, and produces no result.
  - last_grant keeps the aborted requester, so the other requester has priority next.
  - abort in IDLE has no effect.
- When undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- req0_valid=1, req0_data=8'h6A, res_ready=1 → req0_ready pulses on 1 edge; res_valid high after 8 edges; res_id=0, res_cnt_a=2, res_cnt_b=2.
- req1 only, data=8'hAA → res_id=1, cnt_a=3, cnt_b=3. Then data=8'hFF → cnt_a=0, cnt_b=0.
- Both valid continuously after reset (req0=8'h55, req1=8'h00), res_ready=1 → grant order 0,1,0,1. Results (3,3) and (0,0) alternate; ≥1 idle cycle between results.
- Result held: res_ready=0 for 5 cycles after res_valid → res_valid, id and counts stable; busy=1; both reqN_ready=0; accept resumes 1 cycle after res_ready.
- reset_n pulsed low on the 3rd SHIFT cycle → all outputs 0 immediately; no result produced. After release with both valid, req0 is granted first.
- PATTERN_SCAN_ABORT_EN defined, abort on the 4th SHIFT cycle of req0 with req1 also valid → no res_valid; state IDLE next edge; req1 granted next.
